// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-port round-robin Wishbone B4 pipelined bus arbiter
module wb_arbiter2 #(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int MAXBURST     = 16,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    // requester A
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    // requester B
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    // shared master port
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    // A zero-length counter is illegal, so MAXBURST=0 keeps one dummy bit
    localparam int BW = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAXBURST);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_A    = 2'd1;
    localparam logic [1:0] OWN_B    = 2'd2;

    logic [1:0]      r_owner;
    logic            r_last;     // 0: A served last, 1: B served last
    logic [BW-1:0]   r_beats;

    logic            w_own_a;
    logic            w_own_b;
    logic            w_cyc;
    logic            w_other_cyc;
    logic            w_limit;
    logic            w_stb_req;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_sel;
    logic            w_blank;

    assign w_own_a     = (r_owner == OWN_A);
    assign w_own_b     = (r_owner == OWN_B);
    assign w_cyc       = (w_own_a && i_a_cyc) || (w_own_b && i_b_cyc);
    assign w_other_cyc = (w_own_a && i_b_cyc) || (w_own_b && i_a_cyc);
    // Limit only blocks new strobes; it drops the moment the other side gives up
    assign w_limit     = (MAXBURST != 0) && (r_beats == BEAT_MAX) && w_other_cyc;

    // Ownership: rearbitrate whenever the owner is absent or has dropped cyc
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_owner <= OWN_NONE;
            r_last  <= 1'b1;
            r_beats <= '0;
        end else if (!w_cyc) begin
            r_beats <= '0;
            if (i_a_cyc && (!i_b_cyc || r_last)) begin
                r_owner <= OWN_A;
                r_last  <= 1'b0;
            end else if (i_b_cyc) begin
                r_owner <= OWN_B;
                r_last  <= 1'b1;
            end else begin
                r_owner <= OWN_NONE;
            end
        end else if (o_wb_stb && !i_wb_stall && (r_beats != BEAT_MAX)) begin
            r_beats <= r_beats + BW'(1);
        end
    end

    // Select the owner's request fields
    always_comb begin
        w_stb_req = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        w_sel     = '0;
        if (w_own_a) begin
            w_stb_req = i_a_stb;
            w_we      = i_a_we;
            w_addr    = i_a_addr;
            w_data    = i_a_data;
            w_sel     = i_a_sel;
        end else if (w_own_b) begin
            w_stb_req = i_b_stb;
            w_we      = i_b_we;
            w_addr    = i_b_addr;
            w_data    = i_b_data;
            w_sel     = i_b_sel;
        end
    end

    assign o_wb_cyc  = w_cyc;
    assign o_wb_stb  = w_cyc && w_stb_req && !w_limit;
    assign w_blank   = OPT_LOWPOWER && !o_wb_stb;
    assign o_wb_we   = w_blank ? 1'b0 : w_we;
    assign o_wb_addr = w_blank ? '0 : w_addr;
    assign o_wb_data = w_blank ? '0 : w_data;
    assign o_wb_sel  = w_blank ? '0 : w_sel;

    assign o_a_stall = w_own_a ? (i_wb_stall || w_limit) : 1'b1;
    assign o_a_ack   = w_own_a && i_wb_ack;
    assign o_a_err   = w_own_a && i_wb_err;
    assign o_b_stall = w_own_b ? (i_wb_stall || w_limit) : 1'b1;
    assign o_b_ack   = w_own_b && i_wb_ack;
    assign o_b_err   = w_own_b && i_wb_err;

    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - self-checking bench for wb_arbiter2
module tb_wb_arbiter2;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [SW-1:0] a_sel, b_sel;
    logic          a_stall, a_ack, a_err, b_stall, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [SW-1:0] wb_sel;
    logic          wb_stall, wb_ack, wb_err;
    logic [DW-1:0] wb_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(AW), .DW(DW), .MAXBURST(MB), .OPT_LOWPOWER(1'b1)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err), .o_a_data(a_rdata),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err), .o_b_data(b_rdata),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_data), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
    );

    // in = {a_cyc,a_stb,b_cyc,b_stb,stall,ack,err}
    // exp = {cyc,stb,a_stall,b_stall,a_ack,b_ack,a_err,b_err}
    typedef struct {
        logic [6:0] in;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[18];

    // reference model state: owner 0=none 1=A 2=B, who wins the next tie,
    // and how many strobes the current owner has had accepted since its grant
    int   m_own, m_pref, m_acc;
    logic e_cyc, e_stb, e_we, e_as, e_aa, e_ae, e_bs, e_ba, e_be, oth, lim, req;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_sel;
    int   cnt;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0; a_sel = '0;
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0; b_sel = '0;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{7'b0000000, 8'b00110000};
        vecs[1]  = '{7'b1111000, 8'b00110000};
        vecs[2]  = '{7'b1111000, 8'b11010000};
        vecs[3]  = '{7'b1111010, 8'b11011000};
        vecs[4]  = '{7'b1011001, 8'b10010010};
        vecs[5]  = '{7'b0011000, 8'b00010000};
        vecs[6]  = '{7'b0011100, 8'b11110000};
        vecs[7]  = '{7'b0011010, 8'b11100100};
        vecs[8]  = '{7'b1100000, 8'b00100000};
        vecs[9]  = '{7'b1111000, 8'b11010000};
        vecs[10] = '{7'b0011000, 8'b00010000};
        vecs[11] = '{7'b1100000, 8'b00100000};
        vecs[12] = '{7'b0000000, 8'b00010000};
        vecs[13] = '{7'b1111000, 8'b00110000};
        vecs[14] = '{7'b1111000, 8'b11100000};
        vecs[15] = '{7'b1111001, 8'b11100001};
        vecs[16] = '{7'b1100000, 8'b00100000};
        vecs[17] = '{7'b1100000, 8'b11010000};

        idle_in();
        #2 rst_n = 1'b0;
        // outputs held quiet in reset even with active requests and responses
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_addr = 5'h1F; a_sel = 4'hF;
        b_cyc = 1'b1; wb_ack = 1'b1; wb_err = 1'b1;
        #3;
        chk("reset_out", 128'({wb_cyc, wb_stb, a_stall, b_stall, a_ack, b_ack, a_err, b_err,
                               wb_we, wb_addr, wb_sel}),
            128'({8'b00110000, 1'b0, 5'h00, 4'h0}));
        do_reset();

        // table: grant, tie-break, handover, ack/err routing
        for (int i = 0; i < 18; i++) begin
            {a_cyc, a_stb, b_cyc, b_stb, wb_stall, wb_ack, wb_err} = vecs[i].in;
            #1;
            chk($sformatf("vec%0d", i),
                128'({wb_cyc, wb_stb, a_stall, b_stall, a_ack, b_ack, a_err, b_err}),
                128'(vecs[i].exp));
            tick();
        end

        // burst limit: A streams while B waits
        do_reset();
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; b_cyc = 1'b1;
        tick();
        cnt = 0;
        repeat (8) begin
            cnt += int'(wb_stb && !wb_stall);
            tick();
        end
        chk("burst_accepts", 128'(cnt), 128'(MB));
        chk("burst_limit_stall", 128'({a_stall, wb_stb}), 128'(2'b10));
        wb_ack = 1'b1;
        #1;
        chk("burst_ack_drains", 128'(a_ack), 128'(1'b1));
        wb_ack = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
        #1;
        chk("burst_release_idle", 128'(wb_cyc), 128'(1'b0));
        tick();
        chk("burst_b_granted", 128'({wb_cyc, a_stall, b_stall}), 128'(3'b110));
        b_cyc = 1'b0; a_cyc = 1'b1; a_stb = 1'b1;
        tick();
        cnt = 0;
        repeat (10) begin
            cnt += int'(wb_stb && !wb_stall);
            tick();
        end
        chk("burst_unlimited", 128'(cnt), 128'(10));

        // async reset during a stalled strobe
        wb_stall = 1'b1; a_addr = 5'h15;
        #1;
        chk("pre_reset_bus", 128'({wb_cyc, wb_stb, wb_addr}), 128'({2'b11, 5'h15}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_drop", 128'({wb_cyc, wb_stb, wb_addr}), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb_stall = 1'b0; a_cyc = 1'b1; a_stb = 1'b1; b_cyc = 1'b1; b_stb = 1'b1;
        tick();
        chk("post_reset_tie", 128'({a_stall, b_stall}), 128'(2'b01));

        // slave stall during B's burst: bus held, beat count frozen
        do_reset();
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_addr = 5'h0A; b_data = 32'hCAFE0001;
        b_sel = 4'h5;
        tick();
        a_cyc = 1'b1; wb_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall_hold%0d", i),
                128'({b_stall, wb_stb, wb_we, wb_addr, wb_data, wb_sel}),
                128'({3'b111, 5'h0A, 32'hCAFE0001, 4'h5}));
            tick();
        end
        wb_stall = 1'b0;
        cnt = 0;
        repeat (6) begin
            cnt += int'(wb_stb);
            tick();
        end
        chk("stall_then_accepts", 128'(cnt), 128'(MB));
        chk("stall_then_limited", 128'(b_stall), 128'(1'b1));

        // randomized run against the reference model
        do_reset();
        m_own = 0; m_pref = 1; m_acc = 0;
        for (int cyc_n = 0; cyc_n < 1500; cyc_n++) begin
            if ($urandom_range(4) == 0) a_cyc = !a_cyc;
            if ($urandom_range(4) == 0) b_cyc = !b_cyc;
            a_stb = a_cyc && ($urandom_range(1) == 1);
            b_stb = b_cyc && ($urandom_range(1) == 1);
            a_we = ($urandom_range(1) == 1); b_we = ($urandom_range(1) == 1);
            a_addr = AW'($urandom); b_addr = AW'($urandom);
            a_data = $urandom; b_data = $urandom;
            a_sel = SW'($urandom); b_sel = SW'($urandom);
            wb_stall = ($urandom_range(2) == 0);
            wb_ack = ($urandom_range(3) == 0);
            wb_err = ($urandom_range(9) == 0);
            wb_rdata = $urandom;
            #1;
            e_cyc = (m_own == 1) ? a_cyc : (m_own == 2) ? b_cyc : 1'b0;
            oth   = (m_own == 1) ? b_cyc : (m_own == 2) ? a_cyc : 1'b0;
            req   = (m_own == 1) ? a_stb : (m_own == 2) ? b_stb : 1'b0;
            lim   = (m_acc >= MB) && oth;
            e_stb = e_cyc && req && !lim;
            e_we = 1'b0; e_addr = '0; e_data = '0; e_sel = '0;
            if (e_stb && m_own == 1) begin
                e_we = a_we; e_addr = a_addr; e_data = a_data; e_sel = a_sel;
            end else if (e_stb) begin
                e_we = b_we; e_addr = b_addr; e_data = b_data; e_sel = b_sel;
            end
            e_as = (m_own == 1) ? (wb_stall || lim) : 1'b1;
            e_bs = (m_own == 2) ? (wb_stall || lim) : 1'b1;
            e_aa = (m_own == 1) && wb_ack;
            e_ba = (m_own == 2) && wb_ack;
            e_ae = (m_own == 1) && wb_err;
            e_be = (m_own == 2) && wb_err;
            chk($sformatf("rand%0d", cyc_n),
                128'({wb_cyc, wb_stb, wb_we, wb_addr, wb_data, wb_sel, a_stall, a_ack, a_err,
                      b_stall, b_ack, b_err, a_rdata, b_rdata}),
                128'({e_cyc, e_stb, e_we, e_addr, e_data, e_sel, e_as, e_aa, e_ae,
                      e_bs, e_ba, e_be, wb_rdata, wb_rdata}));
            if (!e_cyc) begin
                if (a_cyc && b_cyc) m_own = m_pref;
                else if (a_cyc)     m_own = 1;
                else if (b_cyc)     m_own = 2;
                else                m_own = 0;
                if (m_own != 0) begin
                    m_pref = 3 - m_own;
                    m_acc  = 0;
                end
            end else if (e_stb && !wb_stall) begin
                m_acc++;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
